acc_10bit: RTL
==============

# acc_10bit

Block accumulator placed directly downstream of `adder_10bit`. It takes a stream of 10-bit unsigned samples over a valid/ready handshake and sums each group of `COUNT` samples. The running sum is formed by an internal `adder_10bit` instance that feeds a registered accumulator. Each completed sum is presented on a valid/ready output together with a sticky wrap flag.

## Interface
- `COUNT`, default 4: samples per block; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  10  unsigned sample.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block accepts a sample this cycle.
- `out_data`  out  10  block sum, modulo 1024.
- `out_ovf`  out  1  at least one addition in this block wrapped past 1023.
- `out_valid`  out  1  `out_data` and `out_ovf` are valid.
- `out_ready`  in  1  consumer takes the result.
- `busy`  out  1  at least one sample of the current block has been accepted, or a result is held.

## Operation
- A sample is accepted when `in_valid && in_ready` at a rising edge. A result is taken when `out_valid && out_ready`.
- State machine:
  - IDLE: `acc`=0, `cnt`=0, `ovf`=0, `in_ready`=1, `busy`=0.
    - On accept: `acc`<=`in_data`, `cnt`<=1.
    - Go to HOLD if `COUNT`==1, else to ACC.
  - ACC: `in_ready`=1, `busy`=1.
    - On accept: `acc`<=`adder_10bit(acc, in_data)`, `ovf`<=`ovf | (sum < acc)` (unsigned compare), `cnt`<=`cnt`+1.
    - Go to HOLD when the new `cnt` equals `COUNT`.
  - HOLD: `in_ready`=0, `out_valid`=1, `busy`=1.
    - `out_data`=`acc`, `out_ovf`=`ovf`.
    - On take: clear `acc`, `cnt` and `ovf`, go to IDLE.
- No accepts occur in HOLD. `in_valid` asserted during HOLD is ignored, and the sample must be held by the producer.
- Arithmetic:
  - All additions are unsigned, 10 bits wide; the carry out of bit 9 is discarded by the adder.
  - A wrap is detected only through the `sum < acc` compare.
  - `out_ovf` is sticky for the block and independent of the final value. For example, the final value may be small after a wrap.
- `cnt` is 4 bits wide and never exceeds `COUNT`.
- `in_ready` and `out_valid` depend only on registered state, so there is no combinational path from `in_valid` or `out_ready`.
- Reset asserted at any point, including mid-block or during HOLD:
  - State goes immediately to IDLE with `acc`, `cnt` and `ovf` at 0.
  - The partial block is discarded.
  - `in_ready` is forced to 0 while `rst`=1.

## Timing
- Reset values: `in_ready`=0 while `rst` is high and 1 from the first cycle after release; `out_valid`=0, `out_data`=0, `out_ovf`=0, `busy`=0.
- Latency: `out_valid` rises in the cycle after the edge that accepts sample `COUNT`.
- Take edge: `out_valid` falls in the following cycle and `in_ready` returns to 1 in that same cycle.
- Throughput: with continuous valid and ready, one block every `COUNT`+1 cycles. `in_ready` is low for exactly one cycle per block.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_ovf` are stable.
- Gaps on `in_valid` stall the count without losing state.

## Test plan
- `COUNT`=4, inputs 1,2,3,4 on consecutive cycles with `out_ready`=1 -> `out_valid` for one cycle, one cycle after the 4th accept, with `out_data`=10 and `out_ovf`=0.
- `COUNT`=4, inputs 1000,20,4,0 -> `out_data`=0, `out_ovf`=1. Next block 1,1,1,1 -> `out_data`=4, `out_ovf`=0, confirming the flag clears between blocks.
- `COUNT`=4, inputs 5,6,7,8, `out_ready` held 0 for 5 cycles with `in_valid`=1 and `in_data`=99 during HOLD -> `out_valid` steady at 26, `in_ready`=0 throughout. After `out_ready`=1 the held 99 is the first sample of the next block.
- `COUNT`=4, samples 3,4 accepted, then `rst` pulsed mid-cycle -> `busy`=0, `in_ready`=0 during reset. Next inputs 1,1,1,1 -> `out_data`=4.
- `COUNT`=1, streaming 7,8,9 with `out_ready`=1 -> results 7,8,9. `in_valid` with no gaps -> `in_ready` toggles 1,0 and each result appears every 2 cycles.
- `COUNT`=4, `in_valid` on alternate cycles, values 256,256,256,255 -> `out_data`=1023, `out_ovf`=0, result after the 7th cycle.

Source files
------------

// File: rtl/acc_10bit.sv
// rtl/acc_10bit.sv - block accumulator summing COUNT 10-bit samples with sticky wrap flag
// Contains the adder_10bit helper it instantiates.

module adder_10bit (
  input  logic [9:0] a,
  input  logic [9:0] b,
  output logic [9:0] sum
);
  // Carry out of bit 9 is intentionally dropped; wrap is detected downstream.
  assign sum = a + b;
endmodule

module acc_10bit #(
  parameter int COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] out_data,
  output logic       out_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [3:0] COUNT_W = 4'(COUNT);

  state_t     state, state_next;
  logic [9:0] acc;
  logic [9:0] sum;
  logic [3:0] cnt;
  logic       ovf;
  logic       accept;
  logic       take;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  adder_10bit u_adder (
    .a   (acc),
    .b   (in_data),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (COUNT_W == 4'd1) ? HOLD : ACC;
      ACC:  if (accept && (cnt + 4'd1 == COUNT_W)) state_next = HOLD;
      HOLD: if (take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs come only from registered state (plus reset gating).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = 10'd0;
    out_ovf   = 1'b0;
    case (state)
      IDLE: in_ready = !rst;
      ACC: begin
        in_ready = !rst;
        busy     = 1'b1;
      end
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = acc;
        out_ovf   = ovf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 10'd0;
      cnt <= 4'd0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc <= in_data;
          cnt <= 4'd1;
        end
        ACC: if (accept) begin
          acc <= sum;
          ovf <= ovf | (sum < acc);
          cnt <= cnt + 4'd1;
        end
        HOLD: if (take) begin
          acc <= 10'd0;
          cnt <= 4'd0;
          ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
